// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the M-extension multiply/divide unit: the FSM state
//   encoding, funct3 operation codes and the decode constants that identify an
//   M-extension R-type instruction.
package muldiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [6:0] M_FUNCT7    = 7'b0000001;

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix
//   Conditional two's-complement negation. Used on operand entry to turn a
//   negative signed operand into its magnitude, and in the fix-up step to give
//   the unsigned iterative result its final sign.
// Ports:
//   val_i  W-bit input value
//   neg_i  negate when high
//   val_o  val_i or -val_i
module muldiv_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);
  import muldiv_pkg::*;

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M/RV64M multiply/divide block for the execute stage. One
//   product or quotient bit per cycle: shift-add multiply over a 2*XLEN
//   accumulator, restoring division on operand magnitudes. Signs are stripped
//   on accept and restored in a single FIX cycle.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for an operation, in_ready high
//   MUL    | shift-add multiply, XLEN cycles
//   DIV    | restoring divide, XLEN cycles
//   FIX    | sign restoration and result select
//   DONE   | result presented, held until out_ready
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand-side handshake
//   alu_op, funct3, funct7  instruction encoding
//   rs1, rs2              operands (dividend/multiplicand, divisor/multiplier)
//   out_valid / out_ready result-side handshake
//   result, err           computed value, non-M encoding flag
module muldiv_unit #(
  parameter int unsigned XLEN        = 32,
  parameter logic [1:0]  ALUOP_RTYPE = muldiv_pkg::ALUOP_RTYPE,
  parameter logic [6:0]  M_FUNCT7    = muldiv_pkg::M_FUNCT7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            err
);
  import muldiv_pkg::*;

  localparam int unsigned CW = $clog2(XLEN) + 1;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                a_neg_q, a_neg_d;
  logic                b_neg_q, b_neg_d;
  // Multiplicand magnitude in MUL, divisor magnitude in DIV.
  logic [XLEN-1:0]     opnd_q, opnd_d;
  // MUL: {partial product, remaining multiplier bits}.
  // DIV: low half shifts dividend bits out and quotient bits in.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                err_q, err_d;

  logic                accept;
  logic                is_m;
  logic                a_sgn, b_sgn;
  logic                a_neg_in, b_neg_in;
  logic                ovf;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift, div_trial;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign err       = err_q;

  assign is_m  = (alu_op == ALUOP_RTYPE) && (funct7 == M_FUNCT7);
  assign a_sgn = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                 (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign b_sgn = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign a_neg_in = a_sgn && rs1[XLEN-1];
  assign b_neg_in = b_sgn && rs2[XLEN-1];
  assign ovf = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == {XLEN{1'b1}});

  muldiv_sign_fix #(.W(XLEN)) u_mag_a (.val_i(rs1), .neg_i(a_neg_in), .val_o(a_mag));
  muldiv_sign_fix #(.W(XLEN)) u_mag_b (.val_i(rs2), .neg_i(b_neg_in), .val_o(b_mag));

  muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (
    .val_i(acc_q), .neg_i(a_neg_q ^ b_neg_q), .val_o(prod_fix));
  muldiv_sign_fix #(.W(XLEN)) u_fix_quo (
    .val_i(acc_q[XLEN-1:0]), .neg_i(a_neg_q ^ b_neg_q), .val_o(quo_fix));
  muldiv_sign_fix #(.W(XLEN)) u_fix_rem (
    .val_i(rem_q), .neg_i(a_neg_q), .val_o(rem_fix));

  // Add the multiplicand when the current multiplier LSB is set; the carry
  // lands in the top bit before the whole accumulator shifts right.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   ({1'b0, opnd_q} & {(XLEN+1){acc_q[0]}});

  // Restoring step: a borrow out of the trial subtraction means the shifted
  // remainder stays as is. The kept remainder is always below the divisor, so
  // XLEN bits hold it between steps.
  assign div_shift = {rem_q, acc_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          f3_d     = funct3;
          a_neg_d  = a_neg_in;
          b_neg_d  = b_neg_in;
          cnt_d    = CW'(XLEN);
          result_d = '0;
          err_d    = 1'b0;
          if (!is_m) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (!funct3[2]) begin
            opnd_d  = a_mag;
            acc_d   = {{XLEN{1'b0}}, b_mag};
            state_d = S_MUL;
          end else if (rs2 == '0) begin
            result_d = funct3[1] ? rs1 : {XLEN{1'b1}};
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = funct3[1] ? '0 : rs1;
            state_d  = S_DONE;
          end else begin
            opnd_d  = b_mag;
            acc_d   = {{XLEN{1'b0}}, a_mag};
            rem_d   = '0;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_DIV: begin
        rem_d = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_trial[XLEN]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!f3_q[2]) begin
          result_d = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
          result_d = f3_q[1] ? rem_fix : quo_fix;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Directed and randomised checks of muldiv_unit (XLEN=32) against an
//   arithmetic reference model built from the RISC-V M-extension rules.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the M-extension definitions.
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic bad, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (bad) return 1;
    if (f3[2] && (b == 0)) return 1;
    if (f3[2] && !f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issues one operation, keeps junk on the input side while busy, then checks
  // latency, result/err, stability under backpressure and the return to IDLE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_err,
                        input int exp_lat, input int hold);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, "/in_ready"}, in_ready, 1);
    in_valid = 1'b1; alu_op = op; funct7 = f7; funct3 = f3; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    in_valid = 1'b0;
    chk({tag, "/latency"}, lat, exp_lat);
    chk({tag, "/result"}, result, exp_res);
    chk({tag, "/err"}, err, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, out_valid, 1);
      chk({tag, "/hold_result"}, result, exp_res);
      chk({tag, "/hold_err"}, err, exp_err);
      chk({tag, "/hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/released_valid"}, out_valid, 0);
    chk({tag, "/released_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        bad;
    logic [6:0]  f7;
    int          seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'b0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/in_ready", in_ready, 0);
    chk("reset/out_valid", out_valid, 0);
    chk("reset/result", result, 0);
    chk("reset/err", err, 0);
    rst = 1'b0;
    #1;
    chk("post_reset/in_ready", in_ready, 1);

    run_op("mul",     2'b10, 7'h01, 3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 34, 0);
    run_op("mulh",    2'b10, 7'h01, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 34, 0);
    run_op("mulhu",   2'b10, 7'h01, 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 34, 0);
    run_op("mulhsu",  2'b10, 7'h01, 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0, 34, 0);
    run_op("div",     2'b10, 7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 34, 0);
    run_op("rem",     2'b10, 7'h01, 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, 34, 0);
    run_op("divu",    2'b10, 7'h01, 3'd5, 32'd100,       32'd7,         32'd14,        0, 34, 0);
    run_op("remu",    2'b10, 7'h01, 3'd7, 32'd100,       32'd7,         32'd2,         0, 34, 0);
    run_op("divu0",   2'b10, 7'h01, 3'd5, 32'd1234,      32'd0,         32'hFFFF_FFFF, 0, 1, 0);
    run_op("rem0",    2'b10, 7'h01, 3'd6, 32'd5,         32'd0,         32'd5,         0, 1, 0);
    run_op("div_ovf", 2'b10, 7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 0);
    run_op("rem_ovf", 2'b10, 7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0, 1, 0);
    run_op("bp",      2'b10, 7'h01, 3'd0, 32'd12345,     32'd678,       32'd8369910,   0, 34, 5);
    run_op("bp_next", 2'b10, 7'h01, 3'd5, 32'd1000,      32'd33,        32'd30,        0, 34, 0);
    run_op("bad_f7",  2'b10, 7'h00, 3'd0, 32'd3,         32'd4,         32'h0,         1, 1, 2);
    run_op("after_err", 2'b10, 7'h01, 3'd1, 32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, 0, 34, 0);

    // Reset in the middle of a divide: no result may emerge afterwards.
    in_valid = 1'b1; alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'd4;
    rs1 = 32'd999; rs2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset/out_valid", out_valid, 0);
    chk("midreset/in_ready", in_ready, 0);
    chk("midreset/result", result, 0);
    rst = 1'b0;
    #1;
    chk("midreset/in_ready_after", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midreset/no_result", seen, 0);

    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      bad = ($urandom_range(0, 7) == 0);
      f7 = bad ? 7'h20 : 7'h01;
      run_op($sformatf("rnd%0d_f3_%0d", i, f3), 2'b10, f7, f3, a, b,
             bad ? 32'h0 : ref_res(f3, a, b), bad, ref_lat(bad, f3, a, b),
             $urandom_range(0, 2));
    end

    run_op("bad_aluop", 2'b00, 7'h01, 3'd4, 32'd9, 32'd3, 32'h0, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
